// File: rtl/branch_pred_table_if.sv
// Predict/update bus for the gshare branch prediction table.
// The master drives the fetch PC and the resolved-branch writeback. The slave returns the prediction, the hashed index, the mispredict flag and the global history.
interface branch_pred_table_if #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8
);
  logic [IDX_W-1:0]  pred_pc;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_pred;
  logic              upd_mispred;
  logic [HIST_W-1:0] bhr;

  // Handshake: upd_valid qualifies upd_idx/upd_taken/upd_pred for one rising edge.
  // There is no ready: every presented update is accepted on that edge.
  // The predict side has no valid; it is always live.
  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    input  pred_taken, pred_idx, upd_mispred, bhr
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
    output pred_taken, pred_idx, upd_mispred, bhr
  );
endinterface

// File: rtl/branch_pred_table.sv
// Gshare predictor: 2^IDX_W saturating counters indexed by pred_pc ^ history, with a combinational predict path and one update per clock.
// Optional macro BPT_BYPASS_EN forwards a same-index update into pred_taken in the same cycle.
module branch_pred_table #(
  parameter int CTR_W    = 2,
  parameter int IDX_W    = 8,
  parameter int HIST_W   = 8,
  parameter int INIT_CTR = 1
) (
  input logic                clock,
  input logic                reset,
  branch_pred_table_if.slave bp
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  logic [CTR_W-1:0]  ctr_q [DEPTH];
  logic [HIST_W-1:0] bhr_q;
  logic [HIST_W-1:0] bhr_next;
  logic [IDX_W-1:0]  hist_ext;
  logic [IDX_W-1:0]  pred_idx_w;
  logic [CTR_W-1:0]  pred_ctr;
  logic [CTR_W-1:0]  upd_cur;
  logic [CTR_W-1:0]  upd_next;

  // History is zero-extended into the index space before hashing.
  assign hist_ext   = IDX_W'(bhr_q);
  assign pred_idx_w = bp.pred_pc ^ hist_ext;
  assign pred_ctr   = ctr_q[pred_idx_w];
  assign upd_cur    = ctr_q[bp.upd_idx];

  always_comb begin
    upd_next = upd_cur;
    if (bp.upd_taken) begin
      if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_W'(1);
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - CTR_W'(1);
    end
  end

  generate
    if (HIST_W == 1) begin : g_hist1
      assign bhr_next = bp.upd_taken;
    end else begin : g_histn
      assign bhr_next = {bhr_q[HIST_W-2:0], bp.upd_taken};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
      bhr_q <= '0;
    end else if (bp.upd_valid) begin
      ctr_q[bp.upd_idx] <= upd_next;
      bhr_q             <= bhr_next;
    end
  end

`ifdef BPT_BYPASS_EN
  // Write-through forward of the counter only; pred_idx still hashes the pre-update history.
  logic fwd_hit;
  assign fwd_hit       = bp.upd_valid && !reset && (bp.upd_idx == pred_idx_w);
  assign bp.pred_taken = fwd_hit ? upd_next[CTR_W-1] : pred_ctr[CTR_W-1];
`else
  assign bp.pred_taken = pred_ctr[CTR_W-1];
`endif

  assign bp.pred_idx    = pred_idx_w;
  assign bp.upd_mispred = bp.upd_valid && (bp.upd_pred != bp.upd_taken);
  assign bp.bhr         = bhr_q;
endmodule

// File: tb/tb_branch_pred_table.sv
// Directed bench for branch_pred_table at default parameters (CTR_W=2, IDX_W=8, HIST_W=8, INIT_CTR=1).
module tb_branch_pred_table;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  branch_pred_table_if #(.IDX_W(8), .HIST_W(8)) bp ();

  branch_pred_table #(
    .CTR_W(2), .IDX_W(8), .HIST_W(8), .INIT_CTR(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bp    (bp.slave)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       uv;
    logic [7:0] ui;
    logic       ut;
    logic       up;
    logic [7:0] pc;
    logic       e_pt;
    logic [7:0] e_pi;
    logic       e_mp;
    logic [7:0] e_bhr;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bp.pred_pc   = '0;
    bp.upd_valid = 1'b0;
    bp.upd_idx   = '0;
    bp.upd_taken = 1'b0;
    bp.upd_pred  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drives one update at a negedge; it commits on the following rising edge.
  task automatic drive_upd(input logic [7:0] idx, input logic taken, input logic pred);
    @(negedge clock);
    bp.upd_valid = 1'b1;
    bp.upd_idx   = idx;
    bp.upd_taken = taken;
    bp.upd_pred  = pred;
  endtask

  logic exp_byp;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();

    // Vectors run back to back from reset; expectations are the pre-edge outputs.
    //            uv    ui     ut    up    pc     pt    pi     mp    bhr
    vecs[0]  = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 8'h05, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h04, 1'b1, 8'h05, 1'b0, 8'h01};
    vecs[2]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h06, 1'b1, 8'h05, 1'b0, 8'h03};
    vecs[3]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 8'h05, 1'b1, 8'h07};
    vecs[4]  = '{1'b0, 8'h05, 1'b0, 1'b1, 8'h0B, 1'b1, 8'h05, 1'b0, 8'h0E};
    vecs[5]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h1E, 1'b0, 8'h10, 1'b0, 8'h0E};
    vecs[6]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h0C, 1'b0, 8'h10, 1'b0, 8'h1C};
    vecs[7]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h28, 1'b0, 8'h10, 1'b0, 8'h38};
    vecs[8]  = '{1'b0, 8'h10, 1'b0, 1'b0, 8'h60, 1'b0, 8'h10, 1'b0, 8'h70};
    vecs[9]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h60, 1'b0, 8'h10, 1'b1, 8'h70};
    vecs[10] = '{1'b0, 8'h10, 1'b0, 1'b0, 8'hF1, 1'b0, 8'h10, 1'b0, 8'hE1};

    // Reset state across every index
    do_reset();
    for (int i = 0; i < 256; i++) begin
      bp.pred_pc = 8'(i);
      #1;
      check("rst_pred_taken", 32'(bp.pred_taken), 32'h0);
      check("rst_pred_idx", 32'(bp.pred_idx), 32'(i));
    end
    check("rst_bhr", 32'(bp.bhr), 32'h0);
    check("rst_mispred", 32'(bp.upd_mispred), 32'h0);

    // Saturating up/down, mispredict flag and history hashing
    for (int v = 0; v < 11; v++) begin
      @(negedge clock);
      bp.upd_valid = vecs[v].uv;
      bp.upd_idx   = vecs[v].ui;
      bp.upd_taken = vecs[v].ut;
      bp.upd_pred  = vecs[v].up;
      bp.pred_pc   = vecs[v].pc;
      #1;
      check($sformatf("v%0d_pred_taken", v), 32'(bp.pred_taken), 32'(vecs[v].e_pt));
      check($sformatf("v%0d_pred_idx", v), 32'(bp.pred_idx), 32'(vecs[v].e_pi));
      check($sformatf("v%0d_mispred", v), 32'(bp.upd_mispred), 32'(vecs[v].e_mp));
      check($sformatf("v%0d_bhr", v), 32'(bp.bhr), 32'(vecs[v].e_bhr));
    end

    // History sequence T,N,T,T -> 0x0B; counter at 0x30 goes 1,2,1,2,3
    do_reset();
    drive_upd(8'h30, 1'b1, 1'b0);
    drive_upd(8'h30, 1'b0, 1'b1);
    drive_upd(8'h30, 1'b1, 1'b0);
    drive_upd(8'h30, 1'b1, 1'b1);
    @(negedge clock);
    idle_inputs();
    bp.pred_pc = 8'h0F;
    #1;
    check("hist_bhr", 32'(bp.bhr), 32'h0B);
    check("hist_pred_idx", 32'(bp.pred_idx), 32'h04);
    bp.pred_pc = 8'h3B;
    #1;
    check("hist_idx30", 32'(bp.pred_idx), 32'h30);
    check("hist_pred30", 32'(bp.pred_taken), 32'h1);

    // Same-cycle predict and update at 0x22 with counter 1
    do_reset();
    drive_upd(8'h22, 1'b1, 1'b0);
    bp.pred_pc = 8'h22;
    #1;
`ifdef BPT_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    check("byp_same_cycle", 32'(bp.pred_taken), 32'(exp_byp));
    check("byp_pred_idx", 32'(bp.pred_idx), 32'h22);
    @(negedge clock);
    idle_inputs();
    bp.pred_pc = 8'h23;
    #1;
    check("byp_next_idx", 32'(bp.pred_idx), 32'h22);
    check("byp_next_cycle", 32'(bp.pred_taken), 32'h1);
    check("byp_next_bhr", 32'(bp.bhr), 32'h01);

    // Reset is asynchronous and discards an update presented with it
    @(negedge clock);
    bp.upd_valid = 1'b1;
    bp.upd_idx   = 8'h22;
    bp.upd_taken = 1'b1;
    bp.upd_pred  = 1'b1;
    bp.pred_pc   = 8'h22;
    #1;
    reset = 1'b1;
    #1;
    check("async_bhr", 32'(bp.bhr), 32'h0);
    check("async_pred", 32'(bp.pred_taken), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    bp.pred_pc = 8'h22;
    #1;
    check("post_rst_pred", 32'(bp.pred_taken), 32'h0);
    check("post_rst_bhr", 32'(bp.bhr), 32'h0);
    drive_upd(8'h22, 1'b1, 1'b0);
    @(negedge clock);
    idle_inputs();
    bp.pred_pc = 8'h23;
    #1;
    check("post_rst_inc", 32'(bp.pred_taken), 32'h1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
